// File: rtl/keccak_rnd.sv
// Purpose: one Keccak-f[1600] round (theta, rho, pi, chi, iota) computed combinationally, then registered.
// Latency: 1 cycle from IN_VALID to OUT_VALID; a new state is accepted every cycle.
// Backpressure: none. OUT holds while IN_VALID is low, and OUT_VALID pulses once per accepted input.
module keccak_rnd #(
    parameter int STATE_SIZE = 1600,
    parameter int LANE_W     = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_VALID,
    input  logic [STATE_SIZE-1:0] IN,
    input  logic [63:0]           RND_CONST,
    output logic [STATE_SIZE-1:0] OUT,
    output logic                  OUT_VALID
);

    // Lane (x,y) lives at flat index x+5*y, so it occupies bits [64*(x+5y) +: 64].
    logic [LANE_W-1:0]     w_a   [25];
    logic [LANE_W-1:0]     w_c   [5];
    logic [LANE_W-1:0]     w_d   [5];
    logic [LANE_W-1:0]     w_th  [25];
    logic [LANE_W-1:0]     w_b   [25];
    logic [LANE_W-1:0]     w_chi [25];
    logic [STATE_SIZE-1:0] w_next;

    logic [STATE_SIZE-1:0] r_out;
    logic                  r_vld;

    // Rotate left. Doubling the lane makes n=0 fall out naturally, with no special case.
    function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] v, input int unsigned n);
        logic [2*LANE_W-1:0] t;
        t = {v, v} << n;
        return t[2*LANE_W-1:LANE_W];
    endfunction

    // Rho offsets, indexed by x+5*y.
    function automatic int unsigned rho_off(input int idx);
        case (idx)
            0:  return 0;   1:  return 1;   2:  return 62;  3:  return 28;  4:  return 27;
            5:  return 36;  6:  return 44;  7:  return 6;   8:  return 55;  9:  return 20;
            10: return 3;   11: return 10;  12: return 43;  13: return 25;  14: return 39;
            15: return 41;  16: return 45;  17: return 15;  18: return 21;  19: return 8;
            20: return 18;  21: return 2;   22: return 61;  23: return 56;  24: return 14;
            default: return 0;
        endcase
    endfunction

    // Round datapath: all five steps in one block, so the intermediate arrays have a single driver.
    always_comb begin
        for (int i = 0; i < 25; i++) begin
            w_a[i]   = IN[LANE_W*i +: LANE_W];
            w_th[i]  = '0;
            w_b[i]   = '0;
            w_chi[i] = '0;
        end
        for (int x = 0; x < 5; x++) begin
            w_c[x] = w_a[x] ^ w_a[x+5] ^ w_a[x+10] ^ w_a[x+15] ^ w_a[x+20];
        end
        for (int x = 0; x < 5; x++) begin
            w_d[x] = w_c[(x+4)%5] ^ rotl(w_c[(x+1)%5], 1);
        end
        // Theta.
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                w_th[x+5*y] = w_a[x+5*y] ^ w_d[x];
            end
        end
        // Rho and pi together: lane (x,y) moves to (y, 2x+3y mod 5).
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                w_b[y + 5*((2*x+3*y)%5)] = rotl(w_th[x+5*y], rho_off(x+5*y));
            end
        end
        // Chi works along each row.
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                w_chi[x+5*y] = w_b[x+5*y] ^ (~w_b[(x+1)%5 + 5*y] & w_b[(x+2)%5 + 5*y]);
            end
        end
        // Iota touches lane (0,0) only.
        w_chi[0] = w_chi[0] ^ RND_CONST;
        w_next   = '0;
        for (int i = 0; i < 25; i++) begin
            w_next[LANE_W*i +: LANE_W] = w_chi[i];
        end
    end

    // Output register: a reset wins over a sampled input; an idle cycle holds the state and drops the valid.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out <= '0;
            r_vld <= 1'b0;
        end else begin
            r_vld <= IN_VALID;
            if (IN_VALID) begin
                r_out <= w_next;
            end
        end
    end

    assign OUT       = r_out;
    assign OUT_VALID = r_vld;

endmodule

// File: tb/tb_keccak_rnd.sv
// Scoreboard bench for keccak_rnd: each driven cycle pushes the expected next {valid, state}.
// The monitor pops one entry at every falling edge and compares it against the DUT outputs.
// The reference model derives the rho offsets and round constants independently.
module tb_keccak_rnd;

    logic          CLK;
    logic          RST;
    logic          IN_VALID;
    logic [1599:0] IN;
    logic [63:0]   RND_CONST;
    logic [1599:0] OUT;
    logic          OUT_VALID;

    keccak_rnd #(.STATE_SIZE(1600), .LANE_W(64)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN        (IN),
        .RND_CONST (RND_CONST),
        .OUT       (OUT),
        .OUT_VALID (OUT_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic          vld;
        logic [1599:0] st;
    } exp_t;

    exp_t          sb[$];
    int            n_chk = 0;
    int            n_err = 0;
    int            roff[5][5];
    logic [63:0]   rc_tab[24];
    logic [1599:0] m_out;

    task automatic chk(input string tag, input logic [1599:0] got, input logic [1599:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            for (int i = 0; i < 25; i++) begin
                if (got[64*i +: 64] !== exp[64*i +: 64]) begin
                    $display("FAIL %s lane%0d got=%h exp=%h", tag, i, got[64*i +: 64], exp[64*i +: 64]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [63:0] rl(input logic [63:0] v, input int n);
        if (n == 0) return v;
        return (v << n) | (v >> (64 - n));
    endfunction

    // Reference round, written over a 2-D lane array.
    function automatic logic [1599:0] kround(input logic [1599:0] s, input logic [63:0] rc);
        logic [63:0]   a[5][5];
        logic [63:0]   b[5][5];
        logic [63:0]   c[5];
        logic [63:0]   d;
        logic [1599:0] r;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                a[x][y] = s[64*(x+5*y) +: 64];
        for (int x = 0; x < 5; x++)
            c[x] = a[x][0] ^ a[x][1] ^ a[x][2] ^ a[x][3] ^ a[x][4];
        for (int x = 0; x < 5; x++) begin
            d = c[(x+4)%5] ^ rl(c[(x+1)%5], 1);
            for (int y = 0; y < 5; y++) a[x][y] = a[x][y] ^ d;
        end
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                b[y][(2*x+3*y)%5] = rl(a[x][y], roff[x][y]);
        r = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[64*(x+5*y) +: 64] = b[x][y] ^ (~b[(x+1)%5][y] & b[(x+2)%5][y]);
        r[63:0] = r[63:0] ^ rc;
        return r;
    endfunction

    // Rho offsets from the triangular-number walk; round constants from the degree-8 LFSR.
    task automatic build_tables();
        int          x;
        int          y;
        int          nx;
        logic [7:0]  lfsr;
        logic [63:0] rc;
        roff[0][0] = 0;
        x = 1;
        y = 0;
        for (int t = 0; t < 24; t++) begin
            roff[x][y] = ((t+1)*(t+2)/2) % 64;
            nx = y;
            y  = (2*x + 3*y) % 5;
            x  = nx;
        end
        lfsr = 8'h01;
        for (int i = 0; i < 24; i++) begin
            rc = '0;
            for (int j = 0; j < 7; j++) begin
                if (lfsr[0]) rc[(1<<j)-1] = 1'b1;
                lfsr = lfsr[7] ? ((lfsr << 1) ^ 8'h71) : (lfsr << 1);
            end
            rc_tab[i] = rc;
        end
    endtask

    // Drive one cycle. in_st goes to the DUT; mdl_st feeds the model. use_k replaces the model result with a fixed expectation.
    task automatic drive(input logic rst, input logic vld, input logic [1599:0] in_st,
                         input logic [1599:0] mdl_st, input logic [63:0] rc,
                         input logic use_k, input logic [1599:0] k_st);
        exp_t e;
        RST       = rst;
        IN_VALID  = vld;
        IN        = in_st;
        RND_CONST = rc;
        if (rst) begin
            m_out = '0;
            e.vld = 1'b0;
        end else if (vld) begin
            m_out = use_k ? k_st : kround(mdl_st, rc);
            e.vld = 1'b1;
        end else begin
            e.vld = 1'b0;
        end
        e.st = m_out;
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: one expected entry per clock.
    always @(negedge CLK) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("out_valid", {1599'b0, OUT_VALID}, {1599'b0, e.vld});
            chk("out_state", OUT, e.st);
        end
    end

    function automatic logic [1599:0] rnd_state();
        logic [1599:0] v;
        for (int i = 0; i < 50; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    initial begin
        logic [1599:0] z;
        logic [1599:0] k;
        logic [1599:0] pm;
        logic [1599:0] st;
        logic [1599:0] ms;
        logic [63:0]   rc;
        logic [7:0]    msg[5];

        z     = '0;
        m_out = '0;
        build_tables();
        chk("rc_tab0",  {1536'b0, rc_tab[0]},  {1536'b0, 64'h0000000000000001});
        chk("rc_tab1",  {1536'b0, rc_tab[1]},  {1536'b0, 64'h0000000000008082});
        chk("rc_tab23", {1536'b0, rc_tab[23]}, {1536'b0, 64'h8000000080008008});

        // Reset with valid deliberately high: the output must stay zero.
        drive(1'b1, 1'b1, z, z, 64'h0, 1'b0, z);
        drive(1'b1, 1'b0, z, z, 64'h0, 1'b0, z);

        // The zero state with RC=1 gives only bit 0 set.
        k = '0;
        k[0] = 1'b1;
        drive(1'b0, 1'b1, z, z, 64'h1, 1'b1, k);
        // The zero state with the last round constant gives exactly that constant in lane (0,0).
        k = '0;
        k[63:0] = 64'h8000000080008008;
        drive(1'b0, 1'b1, z, z, 64'h8000000080008008, 1'b1, k);

        // Padded message, each byte bit-reversed into the state, 0x80 closing a 136-byte rate.
        msg[0] = 8'h53; msg[1] = 8'h58; msg[2] = 8'h7B; msg[3] = 8'h99; msg[4] = 8'h01;
        pm = '0;
        for (int b = 0; b < 5; b++)
            for (int i = 0; i < 8; i++)
                pm[8*b + 7 - i] = msg[b][i];
        pm[8*135] = 1'b1;
        drive(1'b0, 1'b1, pm, pm, 64'h1, 1'b0, z);

        // 100 back-to-back random rounds.
        for (int n = 0; n < 100; n++) begin
            st = rnd_state();
            rc = {$urandom(), $urandom()};
            drive(1'b0, 1'b1, st, st, rc, 1'b0, z);
        end

        // Idle: the output holds and the valid drops.
        for (int n = 0; n < 3; n++) drive(1'b0, 1'b0, rnd_state(), z, 64'h0, 1'b0, z);

        // Reset arriving with a valid input discards that input.
        st = rnd_state();
        drive(1'b1, 1'b1, st, st, 64'h1234, 1'b0, z);
        // The first input after release is produced one cycle later.
        st = rnd_state();
        drive(1'b0, 1'b1, st, st, 64'h5678, 1'b0, z);

        // Full permutation of the zero state, feeding the DUT output back in.
        ms = '0;
        drive(1'b0, 1'b1, z, ms, rc_tab[0], 1'b0, z);
        ms = m_out;
        for (int r = 1; r < 24; r++) begin
            drive(1'b0, 1'b1, OUT, ms, rc_tab[r], 1'b0, z);
            ms = m_out;
        end
        chk("kf_lane00", {1536'b0, OUT[63:0]}, {1536'b0, 64'hF1258F7940E1DDE7});
        chk("kf_model_lane00", {1536'b0, ms[63:0]}, {1536'b0, 64'hF1258F7940E1DDE7});

        drive(1'b0, 1'b0, z, z, 64'h0, 1'b0, z);
        for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge CLK);
        #1;
        chk("sb_drain", {1568'b0, 32'(sb.size())}, z);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
